// File: rtl/counter_run_pkg.sv
// Shared types and helpers for the run controller that owns the bounded step counter.
package counter_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 4;
    localparam int MAX_DEF   = 5;
    localparam int NREQ_DEF  = 2;
    localparam int IDX_W_DEF = $clog2(NREQ_DEF);

    typedef logic [IDX_W_DEF-1:0] req_idx_t;

    function automatic logic legal_len(input int unsigned len, input int unsigned max_len);
        return (len != 32'd0) && (len <= max_len);
    endfunction

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned nreq);
        return (idx + 32'd1) % nreq;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [IDX_W-1:0] i_ptr,
    input  logic [NREQ-1:0]  i_req,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_cand;

    // scan requesters starting at the pointer and keep the first hit
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_cand = IDX_W'((int'(i_ptr) + off) % NREQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end else begin
            end
        end
    end

endmodule

// File: rtl/counter_run_ctrl.sv
// Single owner of the bounded step counter: arbitrates run commands and
// enables the counter for exactly the requested number of steps.
module counter_run_ctrl
    import counter_run_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int MAX   = MAX_DEF,
    parameter int NREQ  = NREQ_DEF,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][WIDTH-1:0] req_len,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       abort,
    output logic [WIDTH-1:0]           cnt,
    output logic                       cnt_en,
    output logic                       busy,
    output logic [IDX_W-1:0]           owner,
    output logic                       done,
    output logic                       aborted,
    output logic                       err
);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_len, w_len_nxt;
    logic [IDX_W-1:0] r_owner, w_owner_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic             r_err, w_err_nxt;
    logic             r_aborted, w_aborted_nxt;

    logic [NREQ-1:0]  w_grant;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_valid;
    logic [WIDTH-1:0] w_arb_len;
    logic [WIDTH-1:0] w_cnt_inc;
    logic [IDX_W-1:0] w_owner_succ;
    logic [IDX_W-1:0] w_grant_succ;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_ptr   (r_ptr),
        .i_req   (req_valid),
        .o_grant (w_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_arb_len    = req_len[w_arb_idx];
    assign w_cnt_inc    = r_cnt + WIDTH'(1);
    assign w_owner_succ = IDX_W'(next_idx(32'(r_owner), 32'(NREQ)));
    assign w_grant_succ = IDX_W'(next_idx(32'(w_arb_idx), 32'(NREQ)));

    // next-state, counter update and accept handshake
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_len_nxt     = r_len;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_err_nxt     = 1'b0;
        w_aborted_nxt = 1'b0;
        req_ready     = '0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    req_ready = w_grant;
                    w_len_nxt = w_arb_len;
                    if (legal_len(32'(w_arb_len), 32'(MAX))) begin
                        w_owner_nxt = w_arb_idx;
                        w_cnt_nxt   = '0;
                        w_state_nxt = RUN;
                    end else begin
                        // rejected command still moves the pointer past the offender
                        w_err_nxt = 1'b1;
                        w_ptr_nxt = w_grant_succ;
                    end
                end else begin
                end
            end
            RUN: begin
                if (abort) begin
                    w_cnt_nxt     = '0;
                    w_aborted_nxt = 1'b1;
                    w_ptr_nxt     = w_owner_succ;
                    w_state_nxt   = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = DONE;
                    end else begin
                    end
                end
            end
            DONE: begin
                w_cnt_nxt   = '0;
                w_ptr_nxt   = w_owner_succ;
                w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_len     <= w_len_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_err     <= w_err_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    assign cnt     = r_cnt;
    assign cnt_en  = (r_state == RUN);
    assign busy    = (r_state != IDLE);
    assign owner   = r_owner;
    assign done    = (r_state == DONE);
    assign aborted = r_aborted;
    assign err     = r_err;

endmodule
